jzjpcc_pc_controller: RTL and testbench
=======================================

# jzjpcc_pc_controller

Sequencer for the fetch-stage program counter. It turns execute-stage control-transfer requests, decode hazard stalls, instruction-memory wait and halt/resume requests into the PC's `stall_fetch`, `pcCTWriteEnable` and `controlTransferNewPC` inputs. It also generates the fetch/decode flush and keeps a saturating redirect counter. It sits between the hazard unit and the PC, inside the fetch stage.

## Interface
Parameters:
- `PC_MAX_B`, default 31: MSB of the word-aligned PC; PC fields are `[PC_MAX_B:2]`.
- `FLUSH_CYCLES`, default 2: number of cycles `flush` is high per redirect. The redirect cycle counts as the first. Legal range 1..15.

Ports:
- `clock`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `ctRequest`  input  1  execute stage requests a control transfer (taken branch or jump); one-cycle pulse.
- `ctTarget`  input  `[PC_MAX_B:2]`  target for `ctRequest`; valid only while `ctRequest` is 1.
- `hazardStall`  input  1  decode load-use stall request; level.
- `imemWait`  input  1  instruction memory cannot accept a new address this cycle; level.
- `haltRequest`  input  1  stop fetching; level.
- `resumeRequest`  input  1  leave HALT; pulse.
- `stall_fetch`  output  1  to PC; combinational.
- `pcCTWriteEnable`  output  1  to PC; combinational.
- `controlTransferNewPC`  output  `[PC_MAX_B:2]`  to PC; combinational.
- `flush`  output  1  invalidates the fetch and decode pipeline registers; combinational.
- `halted`  output  1  high while the state is HALT (state decode).
- `ctCount`  output  16  number of applied redirects; saturates at 16'hFFFF.

## Operation
- State register `state` takes values RUN, PENDING, FLUSH and HALT.
- Internal registers: `pendingTarget` `[PC_MAX_B:2]` and `flushCnt` (4 bits).
- Priority order: ctRequest > haltRequest > hazardStall.

RUN:
- If `ctRequest` is 1 and `imemWait` is 0 (an applied redirect):
  - Outputs: `pcCTWriteEnable`=1, `controlTransferNewPC`=`ctTarget`, `stall_fetch`=0 (overrides `hazardStall`), `flush`=1.
  - Next state: FLUSH with `flushCnt`=`FLUSH_CYCLES`-1, or RUN if `FLUSH_CYCLES`=1.
- If `ctRequest` is 1 and `imemWait` is 1:
  - `pendingTarget`<=`ctTarget`.
  - Outputs: `stall_fetch`=1, `flush`=1.
  - Next state: PENDING.
- Else if `haltRequest` is 1 and `imemWait` is 0: `stall_fetch`=1; next state HALT.
- Else `stall_fetch` = `hazardStall` | `imemWait`.

PENDING:
- While `imemWait` is 1: `stall_fetch`=1 and `flush`=1.
- When `imemWait` is 0: apply the redirect using `pendingTarget`, with the same outputs and next-state as an applied redirect.
- A new `ctRequest` in PENDING overwrites `pendingTarget`. If `imemWait` is 0 in that same cycle, `ctTarget` is applied directly.

FLUSH:
- `flush`=1 and `stall_fetch`=`imemWait`; `hazardStall` is ignored (wrong path).
- `flushCnt` decrements every cycle. At 1 → RUN on the next edge.
- A `ctRequest` in FLUSH is handled exactly as in RUN and reloads the counter.
- `haltRequest` is deferred until RUN.

HALT:
- Outputs: `stall_fetch`=1, `flush`=0, `pcCTWriteEnable`=0.
- `resumeRequest` → RUN.
- A `ctRequest` in HALT latches `pendingTarget` → PENDING; `resumeRequest` is ignored that cycle.
- `haltRequest` is ignored while already in HALT.

Default outputs:
- When no redirect is applied: `pcCTWriteEnable`=0 and `controlTransferNewPC`=`pendingTarget`.
- `flush`=0 in RUN outside a redirect cycle.

Counter:
- `ctCount` increments on every cycle with `pcCTWriteEnable`=1.
- It holds at 16'hFFFF.

## Timing
- Reset asserted (`reset`=0):
  - Registers: `state`=RUN, `pendingTarget`=0, `flushCnt`=0, `ctCount`=0, so `halted`=0.
  - Combinational outputs forced: `stall_fetch`=1, `pcCTWriteEnable`=0, `flush`=1.
- After reset deasserts, the first edge behaves per RUN.
- Redirect latency: zero cycles from `ctRequest` to `pcCTWriteEnable` when `imemWait` is 0. The PC holds `ctTarget` after the next edge.
- Under `imemWait`, the redirect is applied in the first cycle `imemWait` is 0.
- `flush` stays high for exactly `FLUSH_CYCLES` cycles, counted from the applied-redirect cycle. Any PENDING cycles come before these and add to them.
- Halt entry takes one edge; `halted` rises the cycle after acceptance. Resume takes one edge, and `stall_fetch` follows RUN rules the cycle after the `resumeRequest` pulse.
- Reset mid-PENDING discards `pendingTarget`; no redirect is applied.

## Test plan
- **Clean redirect** (`FLUSH_CYCLES`=2): in RUN, pulse `ctRequest` with `ctTarget`=30'h0000_0040 and `hazardStall`=1.
  - Same cycle: `pcCTWriteEnable`=1, new PC 'h40, `stall_fetch`=0, `flush`=1.
  - Next cycle: `flush`=1, `pcCTWriteEnable`=0.
  - Third cycle: `flush`=0.
  - `ctCount`=1.
- **Redirect under memory wait**: `imemWait`=1 for 3 cycles, with a `ctRequest` to 'h100 in the first of those cycles.
  - `stall_fetch`=1 and `flush`=1 for all 3 cycles.
  - On the 4th cycle (`imemWait`=0): `pcCTWriteEnable`=1 with 'h100.
- **Overwrite pending**: enter PENDING with target 'h10, then issue a second `ctRequest` to 'h20 while still waiting. Only 'h20 is applied, and `ctCount` increments by 1.
- **Halt/resume**: hold `haltRequest`=1 in RUN.
  - `halted`=1 next cycle; `stall_fetch` stays 1.
  - Drop `haltRequest` and pulse `resumeRequest`: `halted`=0 and `stall_fetch`=`hazardStall`.
  - `haltRequest` raised during FLUSH is taken only after `flush` drops.
- **Saturation and reset**: force 65 537 applied redirects → `ctCount`=16'hFFFF. Then assert `reset`=0 mid-PENDING → all registers cleared, `stall_fetch`=1, `flush`=1, and no redirect applied after release.

Source files
------------

// File: rtl/jzjpcc_pc_controller_if.sv
// Fetch-stage PC sequencer bus: hazard/execute requests in, PC control and status out.
interface jzjpcc_pc_controller_if #(
    parameter int PC_MAX_B = 31
);
    logic                ctRequest;
    logic [PC_MAX_B:2]   ctTarget;
    logic                hazardStall;
    logic                imemWait;
    logic                haltRequest;
    logic                resumeRequest;
    logic                stall_fetch;
    logic                pcCTWriteEnable;
    logic [PC_MAX_B:2]   controlTransferNewPC;
    logic                flush;
    logic                halted;
    logic [15:0]         ctCount;

    modport master (
        output ctRequest, ctTarget, hazardStall, imemWait, haltRequest, resumeRequest,
        input  stall_fetch, pcCTWriteEnable, controlTransferNewPC, flush, halted, ctCount
    );

    modport slave (
        input  ctRequest, ctTarget, hazardStall, imemWait, haltRequest, resumeRequest,
        output stall_fetch, pcCTWriteEnable, controlTransferNewPC, flush, halted, ctCount
    );
endinterface

// File: rtl/jzjpcc_pc_controller.sv
// Fetch-stage PC sequencer: redirects, memory-wait pending, flush window, halt/resume
// and a saturating count of applied redirects.
module jzjpcc_pc_controller #(
    parameter int PC_MAX_B     = 31,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    jzjpcc_pc_controller_if.slave    bus
);
    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;
    localparam logic [1:0] ST_HALT    = 2'd3;

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [1:0]          state_q, state_d;
    logic [PC_MAX_B:2]   pending_target_q, pending_target_d;
    logic [3:0]          flush_cnt_q, flush_cnt_d;
    logic [15:0]         ct_count_q, ct_count_d;

    logic                apply;
    logic [PC_MAX_B:2]   apply_target;
    logic                stall_fetch_c, we_c, flush_c;
    logic [PC_MAX_B:2]   new_pc_c;

    always_comb begin
        state_d          = state_q;
        pending_target_d = pending_target_q;
        flush_cnt_d      = flush_cnt_q;
        apply            = 1'b0;
        apply_target     = bus.ctTarget;
        stall_fetch_c    = 1'b0;
        we_c             = 1'b0;
        flush_c          = 1'b0;
        new_pc_c         = pending_target_q;

        case (state_q)
            ST_RUN, ST_FLUSH: begin
                if (state_q == ST_FLUSH) begin
                    flush_c       = 1'b1;
                    stall_fetch_c = bus.imemWait;
                    flush_cnt_d   = (flush_cnt_q != 4'd0) ? flush_cnt_q - 4'd1 : 4'd0;
                    if (flush_cnt_q <= 4'd1) state_d = ST_RUN;
                end else begin
                    stall_fetch_c = bus.hazardStall | bus.imemWait;
                end
                if (bus.ctRequest && !bus.imemWait) begin
                    apply = 1'b1;
                end else if (bus.ctRequest) begin
                    pending_target_d = bus.ctTarget;
                    stall_fetch_c    = 1'b1;
                    flush_c          = 1'b1;
                    state_d          = ST_PENDING;
                end else if (state_q == ST_RUN && bus.haltRequest && !bus.imemWait) begin
                    stall_fetch_c = 1'b1;
                    state_d       = ST_HALT;
                end
            end
            ST_PENDING: begin
                stall_fetch_c = 1'b1;
                flush_c       = 1'b1;
                if (bus.ctRequest) pending_target_d = bus.ctTarget;
                if (!bus.imemWait) begin
                    apply        = 1'b1;
                    apply_target = bus.ctRequest ? bus.ctTarget : pending_target_q;
                end
            end
            default: begin
                stall_fetch_c = 1'b1;
                if (bus.ctRequest) begin
                    pending_target_d = bus.ctTarget;
                    state_d          = ST_PENDING;
                end else if (bus.resumeRequest) begin
                    state_d = ST_RUN;
                end
            end
        endcase

        // Applied redirect overrides whatever the state logic chose above.
        if (apply) begin
            we_c          = 1'b1;
            new_pc_c      = apply_target;
            stall_fetch_c = 1'b0;
            flush_c       = 1'b1;
            flush_cnt_d   = FLUSH_INIT;
            state_d       = (FLUSH_CYCLES == 1) ? ST_RUN : ST_FLUSH;
        end

        if (!reset) begin
            stall_fetch_c = 1'b1;
            we_c          = 1'b0;
            flush_c       = 1'b1;
        end

        ct_count_d = (we_c && ct_count_q != 16'hFFFF) ? ct_count_q + 16'd1 : ct_count_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_RUN;
            pending_target_q <= '0;
            flush_cnt_q      <= '0;
            ct_count_q       <= '0;
        end else begin
            state_q          <= state_d;
            pending_target_q <= pending_target_d;
            flush_cnt_q      <= flush_cnt_d;
            ct_count_q       <= ct_count_d;
        end
    end

    assign bus.stall_fetch          = stall_fetch_c;
    assign bus.pcCTWriteEnable      = we_c;
    assign bus.controlTransferNewPC = new_pc_c;
    assign bus.flush                = flush_c;
    assign bus.halted               = (state_q == ST_HALT);
    assign bus.ctCount              = ct_count_q;
endmodule

// File: tb/tb_jzjpcc_pc_controller.sv
// Directed bench: redirect targets go through a scoreboard queue checked by a monitor,
// level outputs are checked mid-cycle against hand-computed values.
module tb_jzjpcc_pc_controller;
    localparam int PC_MAX_B = 31;

    logic clock = 1'b0;
    logic reset = 1'b0;

    jzjpcc_pc_controller_if #(.PC_MAX_B(PC_MAX_B)) bus ();

    jzjpcc_pc_controller #(.PC_MAX_B(PC_MAX_B), .FLUSH_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [PC_MAX_B:2] exp_q[$];

    // Monitor: every applied redirect must match the oldest expected target.
    always @(negedge clock) begin
        if (bus.pcCTWriteEnable === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL redirect_unexpected: got pc=%h, required no redirect", bus.controlTransferNewPC);
            end else begin
                logic [PC_MAX_B:2] e;
                e = exp_q.pop_front();
                if (bus.controlTransferNewPC !== e) begin
                    miscompares++;
                    $display("FAIL redirect_target: got %h, required %h", bus.controlTransferNewPC, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic ct, input logic [PC_MAX_B:2] tgt, input logic hz,
                         input logic w, input logic h, input logic r);
        bus.ctRequest     = ct;
        bus.ctTarget      = tgt;
        bus.hazardStall   = hz;
        bus.imemWait      = w;
        bus.haltRequest   = h;
        bus.resumeRequest = r;
    endtask

    task automatic expect_lvl(input string nm, input logic st, input logic fl, input logic ha);
        @(negedge clock);
        chk({nm, "_stall"}, {31'd0, bus.stall_fetch}, {31'd0, st});
        chk({nm, "_flush"}, {31'd0, bus.flush}, {31'd0, fl});
        chk({nm, "_halted"}, {31'd0, bus.halted}, {31'd0, ha});
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        @(negedge clock);
        chk("reset_stall", {31'd0, bus.stall_fetch}, 32'd1);
        chk("reset_we", {31'd0, bus.pcCTWriteEnable}, 32'd0);
        chk("reset_flush", {31'd0, bus.flush}, 32'd1);
        chk("reset_halted", {31'd0, bus.halted}, 32'd0);
        chk("reset_count", {16'd0, bus.ctCount}, 32'd0);

        next_cycle(); reset = 1'b1;
        expect_lvl("idle", 1'b0, 1'b0, 1'b0);

        // Clean redirect with a hazard stall that the redirect overrides.
        next_cycle(); drive(1'b1, 30'h40, 1'b1, 1'b0, 1'b0, 1'b0); exp_q.push_back(30'h40);
        expect_lvl("clean_c0", 1'b0, 1'b1, 1'b0);
        next_cycle(); drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_lvl("clean_c1", 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_lvl("clean_c2", 1'b1, 1'b0, 1'b0);
        chk("clean_count", {16'd0, bus.ctCount}, 32'd1);

        // Redirect under three cycles of memory wait.
        next_cycle(); drive(1'b1, 30'h100, 1'b0, 1'b1, 1'b0, 1'b0); exp_q.push_back(30'h100);
        expect_lvl("wait_c0", 1'b1, 1'b1, 1'b0);
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_lvl("wait_c1", 1'b1, 1'b1, 1'b0);
        next_cycle();
        expect_lvl("wait_c2", 1'b1, 1'b1, 1'b0);
        next_cycle(); bus.imemWait = 1'b0;
        @(negedge clock);
        chk("wait_apply_we", {31'd0, bus.pcCTWriteEnable}, 32'd1);
        next_cycle();
        expect_lvl("wait_flush2", 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_lvl("wait_done", 1'b0, 1'b0, 1'b0);
        chk("wait_count", {16'd0, bus.ctCount}, 32'd2);

        // Overwrite the pending target while still waiting.
        next_cycle(); drive(1'b1, 30'h10, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); drive(1'b1, 30'h20, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0); exp_q.push_back(30'h20);
        next_cycle(); next_cycle();
        expect_lvl("ovr_done", 1'b0, 1'b0, 1'b0);
        chk("ovr_count", {16'd0, bus.ctCount}, 32'd3);

        // Halt and resume.
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_lvl("halt_accept", 1'b1, 1'b0, 1'b0);
        next_cycle();
        expect_lvl("halt_in", 1'b1, 1'b0, 1'b1);
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_lvl("resume_pulse", 1'b1, 1'b0, 1'b1);
        next_cycle(); drive(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_lvl("resume_hz1", 1'b1, 1'b0, 1'b0);
        next_cycle(); bus.hazardStall = 1'b0;
        expect_lvl("resume_hz0", 1'b0, 1'b0, 1'b0);

        // Halt raised during FLUSH is deferred until flush drops.
        next_cycle(); drive(1'b1, 30'h80, 1'b0, 1'b0, 1'b0, 1'b0); exp_q.push_back(30'h80);
        expect_lvl("hflush_c0", 1'b0, 1'b1, 1'b0);
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_lvl("hflush_c1", 1'b0, 1'b1, 1'b0);
        next_cycle();
        expect_lvl("hflush_c2", 1'b1, 1'b0, 1'b0);
        next_cycle();
        expect_lvl("hflush_halted", 1'b1, 1'b0, 1'b1);

        // ctRequest in HALT wins over resume and goes through PENDING.
        next_cycle(); drive(1'b1, 30'h200, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_lvl("hct_c0", 1'b1, 1'b0, 1'b1);
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0); exp_q.push_back(30'h200);
        expect_lvl("hct_apply", 1'b0, 1'b1, 1'b0);
        next_cycle(); next_cycle();
        chk("hct_count", {16'd0, bus.ctCount}, 32'd5);

        // Saturation: back-to-back redirects up to the boundary.
        for (int unsigned i = 0; i < 65529; i++) begin
            next_cycle(); drive(1'b1, 30'(i), 1'b0, 1'b0, 1'b0, 1'b0); exp_q.push_back(30'(i));
        end
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("sat_fffe", {16'd0, bus.ctCount}, 32'h0000_FFFE);
        next_cycle(); drive(1'b1, 30'h3FF, 1'b0, 1'b0, 1'b0, 1'b0); exp_q.push_back(30'h3FF);
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("sat_ffff", {16'd0, bus.ctCount}, 32'h0000_FFFF);
        for (int unsigned i = 0; i < 2; i++) begin
            next_cycle(); drive(1'b1, 30'h500 + 30'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            exp_q.push_back(30'h500 + 30'(i));
        end
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        chk("sat_hold", {16'd0, bus.ctCount}, 32'h0000_FFFF);
        next_cycle(); next_cycle();

        // Reset mid-PENDING discards the pending target.
        next_cycle(); drive(1'b1, 30'h3C0, 1'b0, 1'b1, 1'b0, 1'b0);
        next_cycle(); drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0); reset = 1'b0;
        expect_lvl("rst_mid", 1'b1, 1'b1, 1'b0);
        chk("rst_count", {16'd0, bus.ctCount}, 32'd0);
        chk("rst_newpc", bus.controlTransferNewPC, 32'd0);
        next_cycle(); reset = 1'b1; bus.imemWait = 1'b0;
        expect_lvl("rst_release", 1'b0, 1'b0, 1'b0);
        next_cycle(); next_cycle();
        chk("rst_count_after", {16'd0, bus.ctCount}, 32'd0);

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
